// File: rtl/nv_ram_rwsp_param_pkg.sv
// rtl/nv_ram_rwsp_param_pkg.sv - shared helpers and FSM state type for nv_ram_rwsp_param
package nv_ram_pkg;

    typedef enum logic {
        NV_RAM_INIT  = 1'b0,
        NV_RAM_READY = 1'b1
    } nv_ram_state_t;

    // Ceiling log2, with a floor of 1 so a 2-word RAM still gets one address bit
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Lane width: the last lane absorbs the remainder and may be narrower
    function automatic int lane_w(input int width, input int lanes);
        return (width + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/nv_ram_rwsp_param_if.sv
// rtl/nv_ram_rwsp_param_if.sv - read/write/status bundle between a datapath client and the RAM
interface nv_ram_rwsp_param_if
    import nv_ram_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 129,
    parameter int LANES = 1
);
    localparam int AW = clog2(DEPTH);

    logic [AW-1:0]    ra;
    logic             re;
    logic             ore;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [AW-1:0]    wa;
    logic             we;
    logic [WIDTH-1:0] di;
    logic [LANES-1:0] wmask;
    logic             init_done;
    logic             par_err;

    modport master (
        output ra, re, ore, wa, we, di, wmask,
        input  dout, dout_vld, init_done, par_err
    );

    modport slave (
        input  ra, re, ore, wa, we, di, wmask,
        output dout, dout_vld, init_done, par_err
    );
endinterface

// File: rtl/nv_ram_rwsp_param_init_ctl.sv
// rtl/nv_ram_rwsp_param_init_ctl.sv - INIT/READY sequencer that zero-sweeps the array after reset
module nv_ram_rwsp_init_ctl
    import nv_ram_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_we,
    output logic [AW-1:0] init_wa,
    output logic          init_done
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    nv_ram_state_t state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    // State and sweep counter register; reset restarts the sweep from word 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NV_RAM_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // One word cleared per INIT cycle; leave INIT after the last word
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        init_we   = 1'b0;
        init_wa   = cnt;
        init_done = 1'b0;
        case (state)
            NV_RAM_INIT: begin
                init_we = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = NV_RAM_READY;
                    cnt_nxt   = '0;
                end
            end
            NV_RAM_READY: begin
                init_done = 1'b1;
            end
            default: state_nxt = NV_RAM_INIT;
        endcase
    end
endmodule

// File: rtl/nv_ram_rwsp_param.sv
// rtl/nv_ram_rwsp_param.sv - parametrised 1R1W RAM with lane masks and init sweep; parity via NV_RAM_RWSP_PARITY_EN
module nv_ram_rwsp_param
    import nv_ram_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 129,
    parameter int LANES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             pwrbus_ram_pd,
    nv_ram_rwsp_param_if.slave      bus
);
    localparam int           AW      = clog2(DEPTH);
    localparam int           LW      = lane_w(WIDTH, LANES);
    localparam logic [AW:0]  DEPTH_W = (AW+1)'(DEPTH);

    logic             unused_pwrbus;
    logic             init_done, init_we;
    logic [AW-1:0]    init_wa;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data, wr_bits, user_bits, rd_word;
    logic             wa_ok, ra_ok;

    logic [AW-1:0]    ra_d;
    logic             ra_vld;
    logic [WIDTH-1:0] dout_q;
    logic             dout_vld_q;

    logic [WIDTH-1:0] mem [DEPTH];

    assign unused_pwrbus = ^pwrbus_ram_pd;

    nv_ram_rwsp_init_ctl #(.DEPTH(DEPTH), .AW(AW)) u_init_ctl (
        .clk       (clk),
        .rst       (rst),
        .init_we   (init_we),
        .init_wa   (init_wa),
        .init_done (init_done)
    );

    for (genvar b = 0; b < WIDTH; b++) begin : g_bitmask
        assign user_bits[b] = bus.wmask[b / LW];
    end

    assign wa_ok   = {1'b0, bus.wa} < DEPTH_W;
    assign ra_ok   = {1'b0, ra_d} < DEPTH_W;
    assign rd_word = ra_ok ? mem[ra_d] : '0;

    // Write port source: the sweep owns the array until init_done, then the client
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = init_wa;
        wr_data = '0;
        wr_bits = '0;
        if (!init_done) begin
            wr_en   = init_we;
            wr_bits = '1;
        end else if (bus.we && wa_ok) begin
            wr_en   = 1'b1;
            wr_addr = bus.wa;
            wr_data = bus.di;
            wr_bits = user_bits;
        end
    end

    // Array write merges only the enabled lanes into the stored word
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= (mem[wr_addr] & ~wr_bits) | (wr_data & wr_bits);
        end
    end

    // Two-stage read pipeline; dout samples before this edge's write (read-first)
    always_ff @(posedge clk) begin
        if (rst) begin
            ra_d       <= '0;
            ra_vld     <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else if (init_done) begin
            if (bus.re) begin
                ra_d   <= bus.ra;
                ra_vld <= 1'b1;
            end
            if (bus.ore) begin
                dout_q     <= rd_word;
                dout_vld_q <= ra_vld;
            end
        end
    end

`ifdef NV_RAM_RWSP_PARITY_EN
    logic [LANES-1:0] wr_par, wr_lanes, rd_par, rd_par_st;
    logic [LANES-1:0] par_mem [DEPTH];
    logic             par_err_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane_par
        localparam int LO = i * LW;
        localparam int HI = (((i + 1) * LW) < WIDTH ? ((i + 1) * LW) : WIDTH) - 1;
        assign wr_par[i] = ^wr_data[HI:LO];
        assign rd_par[i] = ^rd_word[HI:LO];
    end

    assign wr_lanes  = init_done ? bus.wmask : '1;
    assign rd_par_st = ra_ok ? par_mem[ra_d] : '0;

    // Parity array follows the data array lane-for-lane
    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_mem[wr_addr] <= (par_mem[wr_addr] & ~wr_lanes) | (wr_par & wr_lanes);
        end
    end

    // Parity flag is captured alongside dout so the two always describe the same word
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if (init_done && bus.ore) begin
            par_err_q <= ra_vld & (|(rd_par ^ rd_par_st));
        end
    end

    assign bus.par_err = par_err_q;
`else
    assign bus.par_err = 1'b0;
`endif

    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.init_done = init_done;
endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// tb/tb_nv_ram_rwsp_param.sv - directed self-checking bench for nv_ram_rwsp_param (DEPTH=8, WIDTH=129, LANES=4)
module tb_nv_ram_rwsp_param;
    localparam int DEPTH = 8;
    localparam int WIDTH = 129;
    localparam int LANES = 4;

    logic        clk;
    logic        rst;
    logic [31:0] pwrbus_ram_pd;
    int          n_checks;
    int          n_fail;

    nv_ram_rwsp_param_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LANES(LANES)) bus ();

    nv_ram_rwsp_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk           (clk),
        .rst           (rst),
        .pwrbus_ram_pd (pwrbus_ram_pd),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [WIDTH-1:0] d, input logic [LANES-1:0] m);
        bus.we = 1'b1; bus.wa = a; bus.di = d; bus.wmask = m;
        tick();
        bus.we = 1'b0; bus.wmask = '0;
    endtask

    task automatic do_read(input logic [2:0] a);
        bus.re = 1'b1; bus.ra = a;
        tick();
        bus.re = 1'b0; bus.ore = 1'b1;
        tick();
        bus.ore = 1'b0;
    endtask

    logic [WIDTH-1:0] exp_w, val_a, val_b, val_c, val_d, ones;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pwrbus_ram_pd = 32'hdead_beef;
        ones = '1;
        bus.ra = '0; bus.re = 1'b0; bus.ore = 1'b0;
        bus.wa = '0; bus.we = 1'b0; bus.di = '0; bus.wmask = '0;
        rst = 1'b1;
        repeat (3) tick();

        check_val("rst_dout",      bus.dout, '0);
        check_val("rst_dout_vld",  WIDTH'(bus.dout_vld), '0);
        check_val("rst_init_done", WIDTH'(bus.init_done), '0);
        check_val("rst_par_err",   WIDTH'(bus.par_err), '0);

        // Release with client traffic present; pulse reset after 4 sweep words
        rst = 1'b0;
        bus.we = 1'b1; bus.wa = 3'd1; bus.di = ones; bus.wmask = '1;
        bus.re = 1'b1; bus.ra = 3'd1; bus.ore = 1'b1;
        repeat (4) tick();
        check_val("init_mid", WIDTH'(bus.init_done), '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (7) tick();
        check_val("init_7cyc", WIDTH'(bus.init_done), '0);
        tick();
        check_val("init_8cyc", WIDTH'(bus.init_done), 1);
        bus.we = 1'b0; bus.re = 1'b0; bus.ore = 1'b0; bus.wmask = '0;
        check_val("init_no_vld", WIDTH'(bus.dout_vld), '0);
        check_val("init_no_dout", bus.dout, '0);

        // Every word cleared by the sweep, including the one targeted during INIT
        for (int a = 0; a < DEPTH; a++) begin
            do_read(3'(a));
            check_val($sformatf("clr_dout%0d", a), bus.dout, '0);
            check_val($sformatf("clr_vld%0d", a), WIDTH'(bus.dout_vld), 1);
            check_val($sformatf("clr_par%0d", a), WIDTH'(bus.par_err), '0);
        end

        // Lane masking: lanes 0 and 2 are [32:0] and [98:66]
        exp_w = ((WIDTH'(1) << 33) - 1) | (((WIDTH'(1) << 33) - 1) << 66);
        do_write(3'd3, ones, 4'b0101);
        do_read(3'd3);
        check_val("lane_0101", bus.dout, exp_w);
        exp_w = exp_w | (((WIDTH'(1) << 30) - 1) << 99);
        do_write(3'd3, ones, 4'b1000);
        do_read(3'd3);
        check_val("lane_1000", bus.dout, exp_w);
        do_write(3'd3, '0, 4'b0000);
        do_read(3'd3);
        check_val("lane_none", bus.dout, exp_w);

        // Read-first collision on word 5
        val_a = {1'b1, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210};
        val_b = {1'b0, 64'h5555_aaaa_5555_aaaa, 64'h1111_2222_3333_4444};
        do_write(3'd5, val_a, '1);
        bus.re = 1'b1; bus.ra = 3'd5;
        tick();
        bus.re = 1'b0;
        bus.we = 1'b1; bus.wa = 3'd5; bus.di = val_b; bus.wmask = '1; bus.ore = 1'b1;
        tick();
        bus.we = 1'b0; bus.wmask = '0;
        check_val("coll_old", bus.dout, val_a);
        tick();
        bus.ore = 1'b0;
        check_val("coll_new", bus.dout, val_b);

        // re and ore together: ore sees the previous address (5)
        val_c = {1'b1, 128'h0f0f_0f0f_f0f0_f0f0_cafe_babe_0000_0001};
        do_write(3'd2, val_c, '1);
        bus.re = 1'b1; bus.ra = 3'd2; bus.ore = 1'b1;
        tick();
        bus.re = 1'b0;
        check_val("reore_prev", bus.dout, val_b);
        tick();
        bus.ore = 1'b0;
        check_val("reore_next", bus.dout, val_c);

        // Output stage holds while ore is low
        val_d = {1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_7777};
        do_write(3'd4, val_d, '1);
        do_read(3'd4);
        check_val("hold_base", bus.dout, val_d);
        bus.re = 1'b1; bus.ra = 3'd2;
        tick();
        bus.re = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_val($sformatf("hold_n%0d", k), bus.dout, val_d);
        end
        check_val("hold_vld", WIDTH'(bus.dout_vld), 1);
        bus.ore = 1'b1;
        tick();
        bus.ore = 1'b0;
        check_val("hold_upd", bus.dout, val_c);

`ifdef NV_RAM_RWSP_PARITY_EN
        do_write(3'd6, val_a, '1);
        dut.mem[6][0] = ~dut.mem[6][0];
        do_read(3'd6);
        check_val("par_dout6", bus.dout, val_a ^ WIDTH'(1));
        check_val("par_err6", WIDTH'(bus.par_err), 1);
        do_read(3'd7);
        check_val("par_err7", WIDTH'(bus.par_err), '0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nv_ram_rwsp_param.md
# nv_ram_rwsp_param

Parametrised 1R1W synchronous RAM model: the successor to the fixed-size `nv_ram_rwsp_*` family. It supports any depth and width, per-lane write masking, a self-clearing initialisation sequencer and a qualified output stage. It sits wherever NVDLA datapath buffers currently instantiate a fixed `nv_ram_rwsp_DxW` model. It keeps the same registered-address/registered-output read pipeline (`re` then `ore`).

## Interface
- `DEPTH`, 8: number of words, ≥2; `AW = clog2(DEPTH)` is derived.
- `WIDTH`, 129: data bits per word.
- `LANES`, 1: write-mask lanes. Lane width `LW = ceil(WIDTH/LANES)`. Lane i covers bits `[i*LW, min((i+1)*LW, WIDTH)-1]`; the last lane may be narrower.
- `clk`  in  1  sole clock; all logic is posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `ra`  in  AW  read address.
- `re`  in  1  read-address capture enable.
- `ore`  in  1  output-register enable.
- `dout`  out  WIDTH  registered read data.
- `dout_vld`  out  1  `dout` holds data from an accepted read.
- `wa`  in  AW  write address.
- `we`  in  1  write enable.
- `di`  in  WIDTH  write data.
- `wmask`  in  LANES  per-lane write enable; 1 means write the lane.
- `init_done`  out  1  initialisation sweep complete; the RAM accepts traffic.
- `par_err`  out  1  parity error on the current `dout`; see Configuration.
- `pwrbus_ram_pd`  in  32  power-down bus; carried for compatibility and functionally ignored.

## Operation
- Two-state FSM.
  - INIT is entered on `rst`. A counter runs 0..DEPTH-1 and writes all-zero (with zero parity) to one word per cycle. After writing word DEPTH-1 the FSM moves to READY.
  - READY holds until `rst`.
- In INIT, `re`, `we` and `ore` are ignored: no array write, no `ra_d` capture, no output update.
- Write (READY): when `we`=1, for each lane with `wmask[i]`=1, `M[wa]` lane i is set to `di` lane i. Unmasked lanes are unchanged. `we` with `wmask`=0 is a no-op.
- Read stage 1 (READY): when `re`=1, `ra_d` is set to `ra` and sticky `ra_vld` is set to 1. `ra_d` holds while `re`=0.
- Read stage 2 (READY): when `ore`=1, `dout` is set to `M[ra_d]` and `dout_vld` is set to `ra_vld`. `dout`/`dout_vld` hold while `ore`=0.
- Out-of-range addresses (≥DEPTH when DEPTH is not a power of 2):
  - A write is dropped.
  - A read returns zero and sets `dout_vld` as normal.

## Timing
- Reset values: `dout`=0, `dout_vld`=0, `par_err`=0, `init_done`=0, `ra_d`=0, `ra_vld`=0, init counter=0.
- `init_done` rises exactly DEPTH cycles after the first cycle with `rst` deasserted.
- Read latency: `re` in cycle N and `ore` in cycle N+1 give `dout` valid from cycle N+2.
- Write in cycle N, then `re` in cycle N+1 to the same address, returns the new data.
- Same-cycle collision (`we` to `wa`==`ra_d` with `ore`=1): `dout` captures the OLD contents (read-first). The new data is visible to the next `ore`.
- `re` and `ore` in the same cycle: `ore` uses the previous `ra_d`. The new address takes effect on the next `ore`.
- Reset asserted mid-operation (any state, including mid-INIT):
  - All outputs return to reset values on the next edge.
  - INIT restarts from word 0.
  - Array contents are undefined until re-cleared.

## Configuration
- `NV_RAM_RWSP_PARITY_EN` defined:
  - Each lane stores one extra even-parity bit, computed from the written lane data.
  - When `ore`=1, every lane of `M[ra_d]` is checked, and `par_err` is set to the OR of the lane mismatches AND `ra_vld`.
  - `par_err` updates only with `ore`, in lockstep with `dout`.
- Not defined: no parity storage; `par_err` is tied to 0.

## Structure
- Package `nv_ram_pkg`:
  - `clog2` function.
  - Lane-width helper `lane_w(WIDTH, LANES)`.
  - FSM state enum `{NV_RAM_INIT, NV_RAM_READY}`.
- Sub-module `nv_ram_rwsp_init_ctl` holds the INIT/READY FSM, the init address counter and `init_done`, and drives internal `init_we`/`init_wa`.
- The top level muxes init versus user writes, and holds the array, the read pipeline and optional parity.

## Test plan
- Reset release, DEPTH=8 -> `init_done` low for 8 cycles, then high. A read of every address returns 0 with `dout_vld`=1 and `par_err`=0.
- LANES=4, WIDTH=129 (LW=33):
  - Write `wa`=3, `di`=all-ones, `wmask`=4'b0101 -> readback bits [32:0] and [98:66] are 1, all other bits are 0.
  - A second write with `wmask`=4'b1000 -> additionally sets bits [128:99].
- Collision: `M[5]`=A, `ra_d`=5, `we`=1 `wa`=5 `di`=B with `ore`=1 in the same cycle -> `dout`=A. The next `ore` gives `dout`=B.
- `re`=1 with `ra`=2 in cycle N, `ore` held low until N+4 -> `dout`/`dout_vld` unchanged through N+4 and update at N+5 to `M[2]`.
- Traffic during INIT (`we`=1 to addr 1, `re`, `ore`) -> no effect: after `init_done`, `M[1]`=0 and `dout_vld`=0. `rst` pulsed at init count 4 -> the sweep restarts, with `init_done` 8 cycles after release.
- With `NV_RAM_RWSP_PARITY_EN` defined, flip one stored bit of word 6 via backdoor, then read word 6 -> `par_err`=1 with that `dout`. A read of word 7 then gives `par_err`=0.
